// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one external memory port between instruction fetch (ibus)
// and load/store (dbus). Round-robin on ties, latched request, one-cycle ack
// back to the winner, and a wait-state watchdog that parks the port on a hung memory.
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch requester
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   // load/store requester
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   // external memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   // status
   output logic                stall,
   output logic                bus_err,
   output logic                grant_d
);

   localparam int BE_W = DATA_W / 8;
   // last wait-cycle index before the watchdog trips
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

   // latched copy of the winning request; drives the memory port while BUSY
   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   state_t      state_q, state_d;
   mem_cmd_t    cmd_q, cmd_d;
   logic        mem_req_q, mem_req_d;
   logic        gnt_q, gnt_d;          // 1 = dbus owns current/last transaction
   logic        last_d_q, last_d_d;    // 1 = last grant went to dbus
   logic [7:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;

   // a requester being acked this cycle is still holding req; don't re-grant it
   logic i_elig, d_elig, pick_d, pick_i;
   assign i_elig = i_req & ~i_ack_q;
   assign d_elig = d_req & ~d_ack_q;
   // on a tie, the side that did not win last time goes first
   assign pick_d = d_elig & (~i_elig | ~last_d_q);
   assign pick_i = i_elig & ~pick_d;

   // next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      mem_req_d = mem_req_q;
      gnt_d     = gnt_q;
      last_d_d  = last_d_q;
      cnt_d     = cnt_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (pick_d || pick_i) begin
               state_d   = BUSY;
               mem_req_d = 1'b1;
               gnt_d     = pick_d;
               last_d_d  = pick_d;
               cnt_d     = 8'd0;
               if (pick_d) begin
                  cmd_d.we    = d_we;
                  cmd_d.be    = d_be;
                  cmd_d.addr  = d_addr;
                  cmd_d.wdata = d_wdata;
               end else begin
                  // fetches are always full-word reads
                  cmd_d.we    = 1'b0;
                  cmd_d.be    = {BE_W{1'b1}};
                  cmd_d.addr  = i_addr;
                  cmd_d.wdata = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (gnt_q) begin
                  d_rdata_d = mem_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = mem_rdata;
                  i_ack_d   = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ERROR;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ERROR: begin
            // terminal until reset: port parked, error flagged
            mem_req_d = 1'b0;
            err_d     = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // state register; async reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         mem_req_q <= 1'b0;
         gnt_q     <= 1'b0;
         last_d_q  <= 1'b0;
         cnt_q     <= 8'd0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         mem_req_q <= mem_req_d;
         gnt_q     <= gnt_d;
         last_d_q  <= last_d_d;
         cnt_q     <= cnt_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         err_q     <= err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = cmd_q.we;
   assign mem_be    = cmd_q.be;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign grant_d   = gnt_q;
   assign bus_err   = err_q;

   // gated by reset so every output reads 0 while reset is held
   assign stall = rst & ((i_req & ~i_ack_q) | (d_req & ~d_ack_q));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter with a small wait-state memory.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_req, mem_we, mem_ack, stall, bus_err, grant_d;
   logic [3:0]  mem_be;

   // memory model knobs
   logic        mem_en;
   int          mem_wait;
   int          wcnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .bus_err(bus_err), .grant_d(grant_d)
   );

   // memory: acks after mem_wait extra cycles of mem_req; fixed read pattern
   assign mem_ack   = mem_en & mem_req & (wcnt == mem_wait);
   assign mem_rdata = (mem_addr == 32'h100) ? 32'h0050_0093 : (mem_addr ^ 32'hA5A5_0000);

   // wait-cycle counter of the memory model
   always_ff @(posedge clk) begin
      if (!mem_req || mem_ack) wcnt <= 0;
      else                     wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; d_be = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_en = 1; mem_wait = 0;

      // reset state
      #3;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_i_ack",   i_ack,   0);
      chk("rst_d_ack",   d_ack,   0);
      chk("rst_stall",   stall,   0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_grant_d", grant_d, 0);
      chk("rst_i_rdata", i_rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // single fetch, zero wait states
      i_req = 1; i_addr = 32'h100;
      #1;
      chk("f_stall_req", stall, 1);
      chk("f_memreq_n",  mem_req, 0);
      tick();
      chk("f_mem_req",  mem_req, 1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_we",   mem_we, 0);
      chk("f_mem_be",   mem_be, 4'hF);
      chk("f_mem_wd",   mem_wdata, 0);
      chk("f_noack",    i_ack, 0);
      chk("f_stall_b",  stall, 1);
      tick();
      chk("f_i_ack",    i_ack, 1);
      chk("f_i_rdata",  i_rdata, 32'h0050_0093);
      chk("f_stall_ak", stall, 0);
      chk("f_gnt",      grant_d, 0);
      tick();   // req was still high through the ack cycle
      chk("f_noreissue", mem_req, 0);
      chk("f_ack_once",  i_ack, 0);
      chk("f_rd_hold",   i_rdata, 32'h0050_0093);
      i_req = 0;
      tick();

      // store with 3 wait states; requester fields change mid-transaction
      mem_wait = 3;
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
      tick();
      d_addr = 32'h3000; d_wdata = 32'h1111_2222; d_be = 4'b1100; d_we = 0;
      for (int k = 0; k < 4; k++) begin
         chk("s_mem_req",  mem_req, 1);
         chk("s_mem_we",   mem_we, 1);
         chk("s_mem_be",   mem_be, 4'b0011);
         chk("s_mem_addr", mem_addr, 32'h2000);
         chk("s_mem_wd",   mem_wdata, 32'hDEAD_BEEF);
         chk("s_gnt",      grant_d, 1);
         chk("s_noack",    d_ack, 0);
         tick();
      end
      chk("s_d_ack",   d_ack, 1);
      chk("s_d_rdata", d_rdata, 32'hA5A5_2000);
      chk("s_mem_off", mem_req, 0);
      d_req = 0;
      tick();
      chk("s_ack_once", d_ack, 0);
      chk("s_rd_hold",  d_rdata, 32'hA5A5_2000);
      chk("s_gnt_hold", grant_d, 1);

      // simultaneous requests after reset: dbus first, ibus in d_ack cycle
      do_reset();
      mem_wait = 0;
      for (int r = 0; r < 4; r++) begin
         i_req = 1; d_req = 1; d_we = 0; d_be = 4'hF;
         i_addr = 32'h400 + 32'(r * 4); d_addr = 32'h800 + 32'(r * 4);
         tick();
         chk("t_gnt_d",   grant_d, 1);
         chk("t_addr_d",  mem_addr, 32'h800 + 32'(r * 4));
         tick();
         chk("t_d_ack",   d_ack, 1);
         chk("t_d_rdata", d_rdata, 32'hA5A5_0800 + 32'(r * 4));
         d_req = 0;
         tick();
         chk("t_gnt_i",   grant_d, 0);
         chk("t_mreq_i",  mem_req, 1);
         chk("t_addr_i",  mem_addr, 32'h400 + 32'(r * 4));
         tick();
         chk("t_i_ack",   i_ack, 1);
         chk("t_i_rdata", i_rdata, 32'hA5A5_0400 + 32'(r * 4));
         i_req = 0;
         tick();
         chk("t_idle",    mem_req, 0);
      end

      // after a lone dbus transaction, a tie goes to ibus
      d_req = 1; d_addr = 32'h900;
      tick(); tick();
      chk("l_d_ack", d_ack, 1);
      d_req = 0;
      tick();
      i_req = 1; d_req = 1; i_addr = 32'h440; d_addr = 32'h940;
      tick();
      chk("l_tie_i", grant_d, 0);
      chk("l_addr",  mem_addr, 32'h440);
      tick();
      chk("l_i_ack", i_ack, 1);
      i_req = 0;
      tick();
      chk("l_gnt_d", grant_d, 1);
      chk("l_addr2", mem_addr, 32'h940);
      tick();
      chk("l_d_ack2", d_ack, 1);
      d_req = 0;
      tick();

      // watchdog: memory never acks, TIMEOUT=8
      mem_en = 0;
      d_req = 1; d_addr = 32'h10;
      tick();
      n = 0;
      while (mem_req && n < 30) begin
         n++;
         tick();
      end
      chk("w_req_cycles", 32'(n), 8);
      chk("w_bus_err",    bus_err, 1);
      chk("w_stall",      stall, 1);
      i_req = 1; i_addr = 32'h200;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (mem_req || i_ack || d_ack) seen = 1;
      end
      chk("w_parked",   seen, 0);
      chk("w_err_stk",  bus_err, 1);
      chk("w_stall2",   stall, 1);
      i_req = 0; d_req = 0;

      // async reset in the middle of a transaction
      do_reset();
      chk("r_err_clr", bus_err, 0);
      mem_en = 1; mem_wait = 5;
      d_req = 1; d_we = 0; d_addr = 32'h1234;
      tick();
      chk("r_busy", mem_req, 1);
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("r_mem_req", mem_req, 0);
      chk("r_d_ack",   d_ack, 0);
      chk("r_stall",   stall, 0);
      chk("r_bus_err", bus_err, 0);
      chk("r_gnt",     grant_d, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      mem_wait = 1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         if (d_ack) seen = 1;
      end
      chk("r_fresh_ack", seen, 1);
      chk("r_fresh_rd",  d_rdata, 32'hA5A5_1234);
      d_req = 0;
      tick();
      chk("r_done", mem_req, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
